// File: rtl/cache_line_xfer_pkg.sv
// Shared types and constants for moving one way-line between the cache and SDRAM.
package cache_line_xfer_pkg;

  localparam int unsigned LINE_W             = 128;
  localparam int unsigned WORD_W             = 16;
  localparam int unsigned sdram_access_len   = 8;
  localparam int unsigned sdram_addr_len     = 24;
  localparam int unsigned MEM_ACCESS_TIMEOUT = 128;

  localparam int unsigned CNT_W = $clog2(sdram_access_len);
  localparam int unsigned TMO_W = $clog2(MEM_ACCESS_TIMEOUT);

  typedef logic [31:0]               data_t;
  typedef data_t [3:0]               way_line_t;
  typedef logic [sdram_addr_len-1:0] sdram_addr_t;
  typedef logic [WORD_W-1:0]         sdram_wd_t;

  typedef enum logic [2:0] {
    XFER_IDLE,
    XFER_CMD,
    XFER_WR,
    XFER_RD,
    XFER_RESP
  } xfer_state_t;

endpackage

// File: rtl/cache_line_xfer_if.sv
// Cache request/response and SDRAM burst signals for the line mover.
interface cache_line_xfer_if;
  import cache_line_xfer_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  data_t       req_addr;
  way_line_t   req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  way_line_t   rsp_rdata;
  logic        sd_cmd_valid;
  logic        sd_cmd_ready;
  logic        sd_cmd_write;
  sdram_addr_t sd_addr;
  logic        sd_wdata_req;
  sdram_wd_t   sd_wdata;
  logic        sd_rdata_vld;
  sdram_wd_t   sd_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output sd_cmd_valid, sd_cmd_write, sd_addr, sd_wdata,
    input  sd_cmd_ready, sd_wdata_req, sd_rdata_vld, sd_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  sd_cmd_valid, sd_cmd_write, sd_addr, sd_wdata,
    output sd_cmd_ready, sd_wdata_req, sd_rdata_vld, sd_rdata
  );

endinterface

// File: rtl/cache_line_xfer_shifter.sv
// Line-wide shift register: parallel load, MSB word out, new words enter at the LSB.
module line_word_shifter
  import cache_line_xfer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  way_line_t load_data,
  input  logic      shift_en,
  input  sdram_wd_t shift_in,
  output way_line_t line,
  output sdram_wd_t head
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_data;
    end else if (shift_en) begin
      line_q <= {line_q[LINE_W-WORD_W-1:0], shift_in};
    end
  end

  assign line = line_q;
  assign head = line_q[LINE_W-1 -: WORD_W];

endmodule

// File: rtl/cache_line_xfer.sv
// Splits a writeback line into SDRAM words or rebuilds a fill line, with a per-request timeout.
module cache_line_xfer
  import cache_line_xfer_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cache_line_xfer_if.slave  bus
);

  xfer_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [TMO_W-1:0] tmo_q;
  logic             write_q;
  sdram_addr_t      addr_q;
  logic             req_ready_q;
  logic             cmd_valid_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;

  way_line_t line;
  sdram_wd_t head;
  sdram_wd_t shift_in;
  logic      accept, wr_strobe, rd_strobe, word_strobe, last_word, tmo_hit;

  assign accept      = req_ready_q && bus.req_valid;
  assign wr_strobe   = (state_q == XFER_WR) && bus.sd_wdata_req && !done_q;
  assign rd_strobe   = (state_q == XFER_RD) && bus.sd_rdata_vld && !done_q;
  assign word_strobe = wr_strobe || rd_strobe;
  assign last_word   = word_strobe && (cnt_q == CNT_W'(sdram_access_len - 1));
  assign tmo_hit     = (tmo_q == TMO_W'(MEM_ACCESS_TIMEOUT - 1));
  // Writebacks shift zeros in behind the outgoing words.
  assign shift_in    = rd_strobe ? bus.sd_rdata : '0;

  line_word_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (bus.req_wdata),
    .shift_en  (word_strobe),
    .shift_in  (shift_in),
    .line      (line),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= XFER_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      tmo_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      cmd_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if ((state_q inside {XFER_CMD, XFER_WR, XFER_RD}) && !tmo_hit) begin
        tmo_q <= tmo_q + 1'b1;
      end
      // Counter parks at the last index; done_q marks the eighth word instead of wrapping.
      if (word_strobe) begin
        if (last_word) done_q <= 1'b1;
        else           cnt_q  <= cnt_q + 1'b1;
      end
      case (state_q)
        XFER_IDLE: begin
          if (accept) begin
            addr_q      <= {bus.req_addr[24:4], 3'b000};
            write_q     <= bus.req_write;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            tmo_q       <= '0;
            req_ready_q <= 1'b0;
            cmd_valid_q <= 1'b1;
            state_q     <= XFER_CMD;
          end
        end
        XFER_CMD: begin
          if (tmo_hit) begin
            cmd_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= XFER_RESP;
          end else if (bus.sd_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= write_q ? XFER_WR : XFER_RD;
          end
        end
        XFER_WR, XFER_RD: begin
          // A final word arriving on the timeout cycle still completes cleanly.
          if (last_word) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            state_q     <= XFER_RESP;
          end else if (tmo_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= XFER_RESP;
          end
        end
        XFER_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= XFER_IDLE;
        end
        default: begin
          cmd_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= XFER_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = (rsp_valid_q && !rsp_err_q && !write_q) ? line : '0;
  assign bus.sd_cmd_valid = cmd_valid_q;
  assign bus.sd_cmd_write = write_q;
  assign bus.sd_addr      = addr_q;
  assign bus.sd_wdata     = (state_q == XFER_WR) ? head : '0;

endmodule
